// File: rtl/mem_cmd_arbiter.sv
// mem_cmd_arbiter: round-robin owner of the flash FSM command/data port.
// The grant is held from command issue until op-done or abort.
module mem_cmd_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          in_req_valid,
    input  logic [2*NREQ-1:0]        in_req_opcode,
    input  logic [NREQ-1:0]          in_req_enc_type,
    input  logic [ADDR_W*NREQ-1:0]   in_req_addr,
    output logic [NREQ-1:0]          out_req_ready,
    input  logic [NREQ-1:0]          in_req_wdata_valid,
    input  logic [8*NREQ-1:0]        in_req_wdata,
    output logic [NREQ-1:0]          out_req_wdata_ready,
    output logic [NREQ-1:0]          out_req_rdata_valid,
    output logic [7:0]               out_req_rdata,
    input  logic [NREQ-1:0]          in_req_rdata_ready,
    output logic                     out_cmd_valid,
    output logic [1:0]               out_cmd_opcode,
    output logic                     out_cmd_enc_type,
    output logic [ADDR_W-1:0]        out_cmd_addr,
    input  logic                     in_fsm_cmd_ready,
    output logic                     out_wr_data_valid,
    output logic [7:0]               out_wr_data,
    input  logic                     in_fsm_data_ready,
    input  logic                     in_rd_data_valid,
    input  logic [7:0]               in_rd_data,
    output logic                     out_rd_ready,
    input  logic                     in_op_done,
    input  logic                     in_abort,
    output logic [NREQ-1:0]          out_grant,
    output logic                     out_busy
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_ACTIVE,
        ARB_RELEASE
    } arb_state_t;

    arb_state_t    state;
    arb_state_t    state_nx;
    logic [IW-1:0] rr_last;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          pick_found;
    logic [NREQ-1:0] pick_oh;

    function automatic logic [IW-1:0] rr_step(
        input logic [IW-1:0] base,
        input int            step
    );
        int k;
        k = int'(base) + step;
        if (k >= NREQ) k = k - NREQ;
        return IW'(k);
    endfunction

    // First valid requester strictly after the previous owner, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = rr_step(rr_last, i);
            if (!pick_found && in_req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARB_IDLE: begin
                if (pick_found) state_nx = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (in_abort)              state_nx = ARB_RELEASE;
                else if (in_fsm_cmd_ready) state_nx = ARB_ACTIVE;
            end
            ARB_ACTIVE: begin
                if (in_op_done || in_abort) state_nx = ARB_RELEASE;
            end
            ARB_RELEASE: state_nx = ARB_IDLE;
            default:     state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ARB_IDLE;
            rr_last          <= IW'(NREQ - 1);
            gnt_idx          <= '0;
            out_grant        <= '0;
            out_req_ready    <= '0;
            out_cmd_valid    <= 1'b0;
            out_cmd_opcode   <= '0;
            out_cmd_enc_type <= 1'b0;
            out_cmd_addr     <= '0;
        end else begin
            state         <= state_nx;
            out_req_ready <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        gnt_idx          <= pick_idx;
                        out_grant        <= pick_oh;
                        out_cmd_valid    <= 1'b1;
                        out_cmd_opcode   <=
                            in_req_opcode[2*int'(pick_idx) +: 2];
                        out_cmd_enc_type <= in_req_enc_type[pick_idx];
                        out_cmd_addr     <=
                            in_req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
                    end
                end
                ARB_ISSUE: begin
                    // Abort wins over a same-cycle accept: no ready pulse.
                    if (in_abort) begin
                        out_cmd_valid <= 1'b0;
                    end else if (in_fsm_cmd_ready) begin
                        out_cmd_valid <= 1'b0;
                        out_req_ready <= out_grant;
                    end
                end
                ARB_RELEASE: begin
                    rr_last   <= gnt_idx;
                    out_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_wr_data_valid   = 1'b0;
        out_wr_data         = '0;
        out_req_wdata_ready = '0;
        out_req_rdata_valid = '0;
        out_req_rdata       = '0;
        out_rd_ready        = 1'b0;
        if (state == ARB_ACTIVE) begin
            out_wr_data_valid   = in_req_wdata_valid[gnt_idx];
            out_wr_data         = in_req_wdata[8*int'(gnt_idx) +: 8];
            out_req_wdata_ready = {NREQ{in_fsm_data_ready}} & out_grant;
            out_req_rdata_valid = {NREQ{in_rd_data_valid}} & out_grant;
            out_req_rdata       = in_rd_data;
            out_rd_ready        = in_req_rdata_ready[gnt_idx];
        end
    end

    assign out_busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// tb_mem_cmd_arbiter: randomized requester/FSM traffic with a queue
// scoreboard; a negedge monitor compares commands, grants and byte streams.
module tb_mem_cmd_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 24;

    typedef enum int {P_IDLE, P_ISSUE, P_ACTIVE, P_REL} ph_t;
    typedef struct {
        int                idx;
        logic [1:0]        op;
        logic              enc;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NREQ-1:0]        in_req_valid = '0;
    logic [2*NREQ-1:0]      in_req_opcode = '0;
    logic [NREQ-1:0]        in_req_enc_type = '0;
    logic [ADDR_W*NREQ-1:0] in_req_addr = '0;
    logic [NREQ-1:0]        out_req_ready;
    logic [NREQ-1:0]        in_req_wdata_valid = '0;
    logic [8*NREQ-1:0]      in_req_wdata = '0;
    logic [NREQ-1:0]        out_req_wdata_ready;
    logic [NREQ-1:0]        out_req_rdata_valid;
    logic [7:0]             out_req_rdata;
    logic [NREQ-1:0]        in_req_rdata_ready = '0;
    logic                   out_cmd_valid;
    logic [1:0]             out_cmd_opcode;
    logic                   out_cmd_enc_type;
    logic [ADDR_W-1:0]      out_cmd_addr;
    logic                   in_fsm_cmd_ready = 1'b0;
    logic                   out_wr_data_valid;
    logic [7:0]             out_wr_data;
    logic                   in_fsm_data_ready = 1'b0;
    logic                   in_rd_data_valid = 1'b0;
    logic [7:0]             in_rd_data = '0;
    logic                   out_rd_ready;
    logic                   in_op_done = 1'b0;
    logic                   in_abort = 1'b0;
    logic [NREQ-1:0]        out_grant;
    logic                   out_busy;

    always #5 clk = ~clk;

    mem_cmd_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_req_valid        (in_req_valid),
        .in_req_opcode       (in_req_opcode),
        .in_req_enc_type     (in_req_enc_type),
        .in_req_addr         (in_req_addr),
        .out_req_ready       (out_req_ready),
        .in_req_wdata_valid  (in_req_wdata_valid),
        .in_req_wdata        (in_req_wdata),
        .out_req_wdata_ready (out_req_wdata_ready),
        .out_req_rdata_valid (out_req_rdata_valid),
        .out_req_rdata       (out_req_rdata),
        .in_req_rdata_ready  (in_req_rdata_ready),
        .out_cmd_valid       (out_cmd_valid),
        .out_cmd_opcode      (out_cmd_opcode),
        .out_cmd_enc_type    (out_cmd_enc_type),
        .out_cmd_addr        (out_cmd_addr),
        .in_fsm_cmd_ready    (in_fsm_cmd_ready),
        .out_wr_data_valid   (out_wr_data_valid),
        .out_wr_data         (out_wr_data),
        .in_fsm_data_ready   (in_fsm_data_ready),
        .in_rd_data_valid    (in_rd_data_valid),
        .in_rd_data          (in_rd_data),
        .out_rd_ready        (out_rd_ready),
        .in_op_done          (in_op_done),
        .in_abort            (in_abort),
        .out_grant           (out_grant),
        .out_busy            (out_busy)
    );

    int   nvec = 0;
    int   nerr = 0;
    cmd_t cmd_q[$];
    logic [7:0] wq[$];
    logic [7:0] rq[$];
    ph_t  ph = P_IDLE;
    int   g = 0;
    int   last = NREQ - 1;
    logic [NREQ-1:0] pulse_exp = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: expectations come from the phase model and the queues.
    always @(negedge clk) begin
        cmd_t c;
        logic [7:0] b;
        chk("busy", 64'(out_busy), 64'(ph != P_IDLE));
        chk("grant", 64'(out_grant),
            64'((ph == P_IDLE) ? '0 : oh(g)));
        chk("cmd_valid", 64'(out_cmd_valid), 64'(ph == P_ISSUE));
        chk("req_ready", 64'(out_req_ready), 64'(pulse_exp));
        pulse_exp = '0;
        if (out_cmd_valid && in_fsm_cmd_ready) begin
            if (cmd_q.size() == 0) begin
                chk("cmd_unexpected", 64'(1), 64'(0));
            end else begin
                c = cmd_q.pop_front();
                chk("cmd_owner", 64'(out_grant), 64'(oh(c.idx)));
                chk("cmd_opcode", 64'(out_cmd_opcode), 64'(c.op));
                chk("cmd_enc", 64'(out_cmd_enc_type), 64'(c.enc));
                chk("cmd_addr", 64'(out_cmd_addr), 64'(c.addr));
                pulse_exp = oh(c.idx);
            end
        end
        if (ph == P_ACTIVE) begin
            chk("wdata_ready", 64'(out_req_wdata_ready),
                64'(in_fsm_data_ready ? oh(g) : '0));
            chk("wr_valid", 64'(out_wr_data_valid),
                64'(in_req_wdata_valid[g]));
            chk("rd_ready", 64'(out_rd_ready),
                64'(in_req_rdata_ready[g]));
            chk("rdata_valid", 64'(out_req_rdata_valid),
                64'(in_rd_data_valid ? oh(g) : '0));
            if (out_wr_data_valid && in_fsm_data_ready) begin
                if (wq.size() == 0) begin
                    chk("wbyte_unexpected", 64'(1), 64'(0));
                end else begin
                    b = wq.pop_front();
                    chk("wr_byte", 64'(out_wr_data), 64'(b));
                end
            end
            if (out_req_rdata_valid[g] && out_rd_ready) begin
                if (rq.size() == 0) begin
                    chk("rbyte_unexpected", 64'(1), 64'(0));
                end else begin
                    b = rq.pop_front();
                    chk("rd_byte", 64'(out_req_rdata), 64'(b));
                end
            end
        end else begin
            chk("route_forced_0",
                64'({out_wr_data_valid, out_wr_data,
                     out_req_wdata_ready, out_req_rdata_valid,
                     out_req_rdata, out_rd_ready}), 64'(0));
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, 64'({out_busy, out_grant, out_cmd_valid,
                       out_req_ready, out_cmd_opcode,
                       out_cmd_enc_type, out_cmd_addr,
                       out_req_rdata_valid, out_rd_ready,
                       out_wr_data_valid, out_req_wdata_ready}),
            64'(0));
    endtask

    task automatic clear_inputs();
        in_req_valid       = '0;
        in_fsm_cmd_ready   = 1'b0;
        in_req_wdata_valid = '0;
        in_req_rdata_ready = '0;
        in_fsm_data_ready  = 1'b0;
        in_rd_data_valid   = 1'b0;
        in_op_done         = 1'b0;
        in_abort           = 1'b0;
    endtask

    // endk: 0 done, 1 abort in active, 2 abort in issue,
    //       3 done+abort, 4 async reset mid-active.
    task automatic run_txn(input logic [NREQ-1:0] mask, input int opf,
                           input int nb, input int endk,
                           input int addr_f, input int base_f);
        logic [1:0]        op[NREQ];
        logic              en[NREQ];
        logic [ADDR_W-1:0] ad[NREQ];
        int   e, j, sent, cyc, base;
        logic is_wr, v;
        logic [7:0] by;
        e = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            if (e < 0 && mask[j]) e = j;
        end
        for (int i = 0; i < NREQ; i++) begin
            op[i] = (opf >= 0) ? 2'(opf) : 2'($urandom);
            en[i] = rbit();
            ad[i] = ADDR_W'($urandom);
        end
        if (addr_f >= 0) ad[e] = ADDR_W'(addr_f);
        base  = (base_f >= 0) ? base_f : int'($urandom_range(0, 255));
        is_wr = (op[e] == 2'b10);
        for (int i = 0; i < NREQ; i++) begin
            in_req_opcode[2*i +: 2]           = op[i];
            in_req_enc_type[i]                = en[i];
            in_req_addr[ADDR_W*i +: ADDR_W]   = ad[i];
        end
        in_req_valid = mask;
        in_op_done   = rbit();
        in_abort     = rbit();
        g = e;
        if (endk != 2)
            cmd_q.push_back('{idx: e, op: op[e], enc: en[e], addr: ad[e]});
        @(posedge clk); #1;
        ph         = P_ISSUE;
        in_op_done = 1'b0;
        in_abort   = 1'b0;
        // Scramble requester fields: the latched command must not move.
        if ($urandom_range(0, 3) == 0) in_req_valid = '0;
        in_req_opcode   = (2*NREQ)'($urandom);
        in_req_enc_type = NREQ'($urandom);
        in_req_addr     = (ADDR_W*NREQ)'({$urandom, $urandom, $urandom});
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        if (endk == 2) begin
            in_abort = 1'b1;
            @(posedge clk); #1;
            in_abort = 1'b0;
            ph = P_REL;
        end else begin
            in_fsm_cmd_ready = 1'b1;
            @(posedge clk); #1;
            in_fsm_cmd_ready   = 1'b0;
            ph                 = P_ACTIVE;
            in_req_valid       = '0;
            in_rd_data_valid   = 1'b0;
            in_req_wdata_valid = '0;
            sent = 0;
            cyc  = 0;
            while (sent < nb && cyc < 1000) begin
                in_fsm_data_ready  = rbit();
                in_req_wdata_valid = NREQ'($urandom);
                in_req_wdata       = (8*NREQ)'($urandom);
                in_req_rdata_ready = NREQ'($urandom);
                in_rd_data         = 8'($urandom);
                by = 8'(base + sent);
                v  = rbit();
                if (is_wr) begin
                    in_req_wdata_valid[e]   = v;
                    in_req_wdata[8*e +: 8]  = by;
                    in_rd_data_valid        = 1'b0;
                    if (v && in_fsm_data_ready) begin
                        wq.push_back(by);
                        sent++;
                    end
                end else begin
                    in_req_wdata_valid[e] = 1'b0;
                    in_rd_data_valid      = v;
                    in_rd_data            = by;
                    if (v && in_req_rdata_ready[e]) begin
                        rq.push_back(by);
                        sent++;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
            if (endk == 4) begin
                #2;
                rst_n = 1'b0;
                ph    = P_IDLE;
                #1;
                chk_all_zero("async_reset");
                clear_inputs();
                wq.delete();
                rq.delete();
                @(posedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                last  = NREQ - 1;
                return;
            end
            in_rd_data_valid   = 1'b0;
            in_req_wdata_valid = '0;
            in_fsm_data_ready  = 1'b0;
            case (endk)
                1: in_abort = 1'b1;
                3: begin
                    in_op_done = 1'b1;
                    in_abort   = 1'b1;
                end
                default: in_op_done = 1'b1;
            endcase
            @(posedge clk); #1;
            in_op_done = 1'b0;
            in_abort   = 1'b0;
            ph = P_REL;
        end
        in_rd_data_valid   = rbit();
        in_req_wdata_valid = NREQ'($urandom);
        in_fsm_data_ready  = rbit();
        @(posedge clk); #1;
        ph   = P_IDLE;
        last = e;
    endtask

    initial begin
        logic [NREQ-1:0] m;
        int r;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_txn(3'b001, 3, 2, 0, 0, -1);
        for (int i = 0; i < 4; i++) run_txn(3'b111, -1, 4, 0, -1, -1);
        run_txn(3'b100, 2, 8, 0, 'h012345, 'hA0);
        run_txn(3'b010, 0, 32, 0, -1, -1);
        run_txn(3'b011, 1, 3, 1, -1, -1);
        run_txn(3'b011, -1, 3, 0, -1, -1);
        run_txn(3'b111, 1, 6, 4, -1, -1);
        run_txn(3'b111, -1, 2, 0, -1, -1);
        for (int i = 0; i < 60; i++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            r = int'($urandom_range(0, 5));
            run_txn(m, -1, int'($urandom_range(0, 10)),
                    (r < 3) ? 0 : r - 2, -1, -1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        chk("wq_drained", 64'(wq.size()), 64'(0));
        chk("rq_drained", 64'(rq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
